tff_toggle_sequencer: RTL
=========================

Name: tff_toggle_sequencer

Overview:
Control block that drives the toggle inputs of the 3-bit T-flip-flop bank from raw push-buttons or an internal auto-step timer.
- Synchronises and debounces three buttons, arbitrates between them, and issues single-cycle toggle pulses.
- Keeps a shadow copy of the expected TFF state.
- In auto mode it steps the bank as a 3-bit binary counter at a programmable rate.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synchronised-high samples needed to accept a press, and consecutive all-low samples needed to accept release. Legal range 1 to 2^CNT_W-1.
- AUTO_DIV, 8: sysclk cycles between auto-mode steps. Legal range 1 to 2^CNT_W.
- CNT_W, 16: width of the debounce counter and the divider counter.

Ports:
- sysclk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn  in  3  raw, asynchronous button inputs; bit i requests a toggle of TFF i.
- auto_en  in  1  level; enables auto-step mode.
- t_out  out  3  toggle pulses to the TFF bank; each pulse is high for exactly one cycle.
- shadow  out  3  expected TFF bank state.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-high): t_out=0, shadow=0, busy=0, FSM=IDLE, both counters=0, synchroniser flops=0.
- Synchroniser: 2-flop per btn bit; bs = synchronised btn. The FSM only ever sees bs.

FSM states:
- IDLE:
  - If any bs bit is high: capture idx = lowest set bit (bit 0 has highest priority), clear the debounce counter, go to QUAL.
- QUAL:
  - If bs[idx]=1: the counter increments.
  - If bs[idx]=0: return to IDLE with no pulse.
  - When the counter reaches DEBOUNCE_CYCLES-1 while bs[idx]=1: go to FIRE.
  - Other button bits are ignored in this state.
- FIRE (one cycle):
  - t_out = one-hot(idx).
  - shadow[idx] toggles on the same edge that leaves FIRE.
  - Next state WAIT_REL, counter cleared.
- WAIT_REL:
  - The counter increments while bs==0 and clears on any bs bit high.
  - Return to IDLE when the counter reaches DEBOUNCE_CYCLES-1.
  - No new press is accepted in this state, so a held button yields exactly one pulse.

Latency:
- A clean press that stays high produces t_out high exactly DEBOUNCE_CYCLES+3 rising edges after the first edge at which raw btn is sampled high.

Auto mode:
- The divider counts only while auto_en=1 and the FSM is in IDLE. It clears when auto_en=0.
- At terminal count AUTO_DIV-1, in IDLE, with bs==0:
  - t_out[i] = AND of shadow[i-1:0]; bit 0 is always 1.
  - shadow <= shadow+1, mod 8.
  - The divider wraps to 0.
  - The FSM stays in IDLE, and busy stays 0.
- Simultaneous events:
  - If bs is nonzero at the terminal count, the button wins.
  - The divider holds at terminal and the auto step fires in the first IDLE cycle with bs==0.
  - Manual and auto pulses never occur in the same cycle.
- auto_en deasserted mid-count: the divider clears and no step is issued.

Other boundary conditions:
- Wrap-around: shadow 3'b111 +1 -> 3'b000, with t_out=3'b111.
- DEBOUNCE_CYCLES=1: QUAL and WAIT_REL each last exactly one cycle when their condition is met.
- Reset asserted mid-operation: all state returns to reset values immediately. A button still held after reset release is treated as a new press.

Optional Feature:
- Macro TFF_SEQ_DOWN_EN.
- Defined:
  - Adds input port dir (1 bit).
  - dir=1 makes auto steps count down: t_out[i] = AND of ~shadow[i-1:0], shadow <= shadow-1, mod 8, so 3'b000 -> 3'b111 with t_out=3'b111.
  - dir=0 counts up.
  - dir is sampled only at the terminal-count cycle.
- Not defined: no dir port; auto mode counts up only.

Test Plan:
- Reset, then raw btn=3'b010 held for 20 cycles (DEBOUNCE_CYCLES=4) -> exactly one t_out=3'b010 pulse, 7 edges after the press; shadow=3'b010; busy returns low 4 cycles after release.
- Press held only 2 cycles on btn[0] -> no t_out pulse, shadow unchanged, FSM back in IDLE.
- btn=3'b110 pressed in the same cycle -> pulse on bit 1 only, then pulse on bit 2 only after a full release and a new press.
- auto_en=1, AUTO_DIV=8, no buttons, 64 cycles -> shadow steps 0..7 and back to 0, one step every 8 cycles; the 7->0 step shows t_out=3'b111.
- auto_en=1 with btn[0] rising so that bs goes high on the divider's terminal cycle -> manual pulse 3'b001 first; auto step fires on the first IDLE cycle with bs==0; never two pulses in one cycle.
- Reset asserted during QUAL -> outputs zero immediately; with TFF_SEQ_DOWN_EN defined and dir=1, auto from shadow 0 -> 3'b111 with t_out=3'b111.

Source files
------------

// File: rtl/tff_toggle_sequencer.sv
// Button debouncer, arbiter and auto-step sequencer for a 3-bit T-flip-flop bank.
// Optional macro TFF_SEQ_DOWN_EN adds a dir input that lets auto mode count down.
module tff_toggle_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned AUTO_DIV        = 8,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [2:0] btn,
    input  logic       auto_en,
`ifdef TFF_SEQ_DOWN_EN
    input  logic       dir,
`endif
    output logic [2:0] t_out,
    output logic [2:0] shadow,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_QUAL     = 2'd1;
    localparam logic [1:0] ST_FIRE     = 2'd2;
    localparam logic [1:0] ST_WAIT_REL = 2'd3;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(AUTO_DIV - 1);

    logic [2:0]       sync_q, bs_q;
    logic [1:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [2:0]       shadow_q, shadow_d;
    logic             auto_step;
    logic             auto_down;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        shadow_d  = shadow_q;
        t_out     = 3'b000;
        auto_step = 1'b0;
        auto_down = 1'b0;
`ifdef TFF_SEQ_DOWN_EN
        auto_down = dir;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|bs_q) begin
                    state_d = ST_QUAL;
                    cnt_d   = '0;
                    if (bs_q[0]) begin
                        idx_d = 2'd0;
                    end else if (bs_q[1]) begin
                        idx_d = 2'd1;
                    end else begin
                        idx_d = 2'd2;
                    end
                end
            end
            ST_QUAL: begin
                if (!bs_q[idx_q]) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_FIRE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FIRE: begin
                t_out    = 3'b001 << idx_q;
                shadow_d = shadow_q ^ (3'b001 << idx_q);
                state_d  = ST_WAIT_REL;
                cnt_d    = '0;
            end
            ST_WAIT_REL: begin
                if (|bs_q) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Divider holds at terminal while a button is pending, so the step is deferred, not lost.
        if (!auto_en) begin
            div_d = '0;
        end else if (state_q == ST_IDLE) begin
            if (div_q == DIV_LAST) begin
                if (bs_q == 3'b000) begin
                    div_d     = '0;
                    auto_step = 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        if (auto_step) begin
            if (auto_down) begin
                t_out    = {~shadow_q[1] & ~shadow_q[0], ~shadow_q[0], 1'b1};
                shadow_d = shadow_q - 3'd1;
            end else begin
                t_out    = {shadow_q[1] & shadow_q[0], shadow_q[0], 1'b1};
                shadow_d = shadow_q + 3'd1;
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync_q   <= 3'b000;
            bs_q     <= 3'b000;
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            div_q    <= '0;
            shadow_q <= 3'b000;
        end else begin
            sync_q   <= btn;
            bs_q     <= sync_q;
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
        end
    end

    assign shadow = shadow_q;
    assign busy   = (state_q != ST_IDLE);

endmodule
